// File: rtl/seg_mux_drv_if.sv
// seg_mux_drv_if: digit/blink/brightness inputs and cathode/anode/frame outputs of seg_mux_drv.
// master = application side, slave = display driver.
interface seg_mux_drv_if #(
    parameter int NUM_DIGITS = 8,
    parameter int BRIGHT_W   = 4
);
    logic [6*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   blink_mask;
    logic [BRIGHT_W-1:0]     brightness;
    logic [7:0]              dec_cat;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_tick;
    modport master (output digits, blink_mask, brightness, input dec_cat, an, frame_tick);
    modport slave (input digits, blink_mask, brightness, output dec_cat, an, frame_tick);
endinterface

// File: rtl/seg_mux_drv.sv
// seg_mux_drv: N-digit multiplexed common-anode 7-segment driver with blink, PWM dimming and frame strobe.
// SEG_MUX_GHOST_BLANK_EN blanks the anodes for 2**BRIGHT_W clocks after every digit switch.
module seg_mux_drv #(
    parameter int NUM_DIGITS = 8,
    parameter int CLK_HZ     = 100_000_000,
    parameter int DIGIT_HZ   = 1000,
    parameter int BLINK_HZ   = 2,
    parameter int BRIGHT_W   = 4
) (
    input logic          clock,
    input logic          reset,
    seg_mux_drv_if.slave bus
);
    localparam int DIV       = CLK_HZ / DIGIT_HZ;
    localparam int BLINK_RAW = DIGIT_HZ / (2 * BLINK_HZ);
    localparam int BLINK_DIV = BLINK_RAW > 1 ? BLINK_RAW : 1;
    localparam int DIV_W     = DIV > 1 ? $clog2(DIV) : 1;
    localparam int SEL_W     = $clog2(NUM_DIGITS);
    localparam int BLK_W     = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
    localparam logic [6:0] SEG_ROM [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic [DIV_W-1:0]      r_div_cnt;
    logic [SEL_W-1:0]      r_sel;
    logic [BRIGHT_W-1:0]   r_pwm_cnt;
    logic [BLK_W-1:0]      r_blink_cnt;
    logic                  r_blink_phase;
    logic                  r_frame_tick;
    logic [NUM_DIGITS-1:0] r_an;
    logic [7:0]            r_dec_cat;
    logic                  w_tick;
    logic                  w_last;
    logic                  w_blink_wrap;
    logic                  w_pwm_on;
    logic                  w_blank;
    logic                  w_visible;
    logic [5:0]            w_digit;

    assign w_tick       = r_div_cnt == DIV_W'(DIV - 1);
    assign w_last       = r_sel == SEL_W'(NUM_DIGITS - 1);
    assign w_blink_wrap = r_blink_cnt == BLK_W'(BLINK_DIV - 1);
    assign w_digit      = bus.digits[6*r_sel +: 6];
    assign w_pwm_on     = (&bus.brightness) | (r_pwm_cnt < bus.brightness);
    assign w_visible    = w_digit[5] & w_pwm_on & ~(bus.blink_mask[r_sel] & r_blink_phase) & ~w_blank;

`ifdef SEG_MUX_GHOST_BLANK_EN
    // Set once pwm_cnt has wrapped since the last tick; anodes stay dark until then.
    logic r_pwm_wrapped;
    always_ff @(posedge clock)
        if (reset | w_tick) r_pwm_wrapped <= 1'b0;
        else if (&r_pwm_cnt) r_pwm_wrapped <= 1'b1;
    assign w_blank = ~r_pwm_wrapped;
`else
    assign w_blank = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_div_cnt     <= '0;
            r_sel         <= '0;
            r_pwm_cnt     <= '0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_frame_tick  <= 1'b0;
            r_an          <= '1;
            r_dec_cat     <= 8'hFF;
        end else begin
            r_div_cnt    <= w_tick ? '0 : r_div_cnt + 1'b1;
            r_pwm_cnt    <= w_tick ? '0 : r_pwm_cnt + 1'b1;
            r_frame_tick <= w_tick & w_last;
            if (w_tick) begin
                r_sel         <= w_last ? '0 : r_sel + 1'b1;
                r_blink_cnt   <= w_blink_wrap ? '0 : r_blink_cnt + 1'b1;
                r_blink_phase <= r_blink_phase ^ w_blink_wrap;
            end
            // Digit i drives the anode counted from the MSB end.
            r_an      <= w_visible ? ~(NUM_DIGITS'(1) << (NUM_DIGITS - 1 - int'(r_sel))) : '1;
            r_dec_cat <= {SEG_ROM[w_digit[4:1]], ~w_digit[0]};
        end
    end

    assign bus.an         = r_an;
    assign bus.dec_cat    = r_dec_cat;
    assign bus.frame_tick = r_frame_tick;
endmodule

// File: doc/seg_mux_drv.md
Name: seg_mux_drv

Overview:
Parametrised time-multiplexed 7-segment display driver for N common-anode digits. It generalises the fixed 8-digit scanner with a configurable digit count, clock and refresh rates, per-digit blink, global PWM brightness and a frame-boundary strobe. It sits between the application's digit registers and the board cathode/anode pins.

Parameters:
NUM_DIGITS, 8, number of multiplexed digits (2..16).
CLK_HZ, 100_000_000, input clock frequency.
DIGIT_HZ, 1000, dwell rate; each digit is held for DIV = CLK_HZ/DIGIT_HZ clocks.
BLINK_HZ, 2, blink frequency for masked digits.
BRIGHT_W, 4, brightness control width; DIV must be >= 2**BRIGHT_W.

Ports:
clock  in  1  system clock.
reset  in  1  synchronous, active-high.
digits  in  6*NUM_DIGITS  digit i is at [6i+5:6i]; bit5 = enable, bits4:1 = hex value, bit0 = decimal point (1 = lit).
blink_mask  in  NUM_DIGITS  bit i = 1 makes digit i blink.
brightness  in  BRIGHT_W  0 = dark, all-ones = full on.
dec_cat  out  8  {seg g..a, dp}, active-low, registered.
an  out  NUM_DIGITS  anodes, active-low, registered; digit i drives an[NUM_DIGITS-1-i].
frame_tick  out  1  one-clock pulse when the scan wraps to digit 0.

Behaviour:
- Interface: reset is synchronous and active-high; the clock is clock.
- div_cnt counts 0..DIV-1. tick is asserted for 1 clock when div_cnt == DIV-1, and div_cnt returns to 0.
- sel advances on tick: 0 -> 1 -> ... -> NUM_DIGITS-1 -> 0. The wrap must be explicit and must work for non-power-of-2 NUM_DIGITS.
- frame_tick is registered and asserted in the cycle after the tick that wraps sel to 0.
- pwm_cnt is BRIGHT_W bits wide. It increments every clock and is cleared on tick. pwm_on = (brightness == all-ones) | (pwm_cnt < brightness).
- blink_cnt counts ticks. blink_phase toggles every DIGIT_HZ/(2*BLINK_HZ) ticks (minimum 1).
- Digit d = slice sel is visible when: d.bit5 & pwm_on & ~(blink_mask[sel] & blink_phase).
- When visible: an has exactly one bit low, at an[NUM_DIGITS-1-sel]. Otherwise an = all ones.
- dec_cat = {seg_rom[d.bits4:1], ~d.bit0} regardless of visibility.
- seg_rom is hex 0-F, active-low, bit order g..a: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Latency: an and dec_cat are registered and reflect sel, inputs and counters one clock later. Input changes are visible after 1 clock.
- Reset values: div_cnt = 0, sel = 0, pwm_cnt = 0, blink_cnt = 0, blink_phase = 0, an = all ones, dec_cat = 8'hFF, frame_tick = 0.
- Reset mid-scan: all of the above are restored in the next cycle. The scan then restarts at digit 0 with a full DIV dwell.
- Simultaneous tick and blink toggle: both take effect on the same edge, so the new digit is shown in the new blink phase.
- Brightness changes mid-dwell take effect at the next clock; no glitch beyond one clock.

Optional Feature:
SEG_MUX_GHOST_BLANK_EN.
- Defined: an is forced all ones for the first 2**BRIGHT_W clocks after each tick (pwm_cnt has not yet wrapped since the tick). dec_cat still updates. This removes ghosting on slow anode drivers and costs 1 overflow-flag flop.
- Undefined: anodes switch directly on tick, per the Behaviour section.

Test Plan:
1. Sim params CLK_HZ=1000, DIGIT_HZ=100 (DIV=10), NUM_DIGITS=8, BRIGHT_W=2, brightness=3, all digits enabled with values 0..7. Release reset -> an walks 01111111, 10111111, ... every 10 clocks; dec_cat=1000000_1 while digit 0 is shown; frame_tick pulses once per 80 clocks.
2. NUM_DIGITS=5 -> sel wraps 4 -> 0; an is 5 bits wide and never all-low; frame_tick period is 50 clocks.
3. brightness=1, BRIGHT_W=2 -> an active 1 clock of every 4 within the dwell (pwm_cnt==0 only). brightness=0 -> an stays 11111111.
4. blink_mask=8'b0000_0100, BLINK_HZ=5 -> digit 2 is dark for alternate 10-tick windows; the other digits are unaffected. Digit 3 with bit5=0 -> never lit. dp bit=1 -> dec_cat[0]=0.
5. Assert reset while sel=5 mid-dwell -> next cycle an=all ones, dec_cat=8'hFF. After release, digit 0 is held for 10 clocks.
6. With SEG_MUX_GHOST_BLANK_EN, brightness=3 -> an all ones for the first 4 clocks after each tick, then the digit is lit for 6 clocks.
